// File: rtl/fp32_pkg.sv
// Shared FP32 types, constants and FSM encodings for the sequential divider.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier: {exp, mant} -> zero / normal / inf / nan.
// Denormals (exp == 0) are reported as zero so they flush through the divider.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [30:0] i_op,
    output logic [1:0]  o_cls
);

    fp_class_t w_cls;

    always_comb begin
        if (i_op[30:23] == 8'h00) begin
            w_cls = CLS_ZERO;
        end else if (i_op[30:23] == 8'hFF) begin
            w_cls = (i_op[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else begin
            w_cls = CLS_NORM;
        end
    end

    assign o_cls = w_cls;

endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential FP32 divider, restoring, one quotient bit per cycle, truncating.
// Fixed latency for every operand class; DONE holds until out_ready.
module fp32_divider_seq
    import fp32_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BIAS = EXP_BIAS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
);

    localparam logic [9:0] BIAS_W = 10'(BIAS);

    fp32_t              w_a, w_b;
    logic [1:0]         w_cls_a, w_cls_b;
    logic [9:0]         w_exp_in;
    logic               w_ge;
    logic [23:0]        w_diff;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_mant_n;
    fp32_t              w_res;
    logic               w_ovf, w_unf, w_exc;

    state_t             r_state;
    fp_class_t          r_cls_a, r_cls_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [24:0]        r_rem;
    logic [23:0]        r_div;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic [XLEN-1:0]    r_result;
    logic               r_out_valid, r_ovf, r_unf, r_exc;

    assign w_a = A;
    assign w_b = B;

    fp32_classify u_cls_a (.i_op(A[30:0]), .o_cls(w_cls_a));
    fp32_classify u_cls_b (.i_op(B[30:0]), .o_cls(w_cls_b));

    // Two's-complement wrap is intended: r_exp is read back as signed.
    assign w_exp_in = {2'b00, w_a.exp} - {2'b00, w_b.exp} + BIAS_W;

    // Restoring invariant keeps rem < 2*div, so a successful trial fits 24 bits.
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = r_rem[23:0] - r_div;

    always_comb begin
        w_exp_n  = r_q[24] ? r_exp : (r_exp - 10'sd1);
        w_mant_n = r_q[24] ? r_q[23:1] : r_q[22:0];
        w_res    = {r_sign, w_exp_n[7:0], w_mant_n};
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_exc    = 1'b0;
        if (r_cls_a == CLS_NAN || r_cls_b == CLS_NAN ||
            (r_cls_a == CLS_ZERO && r_cls_b == CLS_ZERO) ||
            (r_cls_a == CLS_INF  && r_cls_b == CLS_INF)) begin
            w_res = QNAN;
            w_exc = 1'b1;
        end else if (r_cls_a == CLS_NORM && r_cls_b == CLS_ZERO) begin
            w_res = POS_INF | {r_sign, 31'd0};
            w_exc = 1'b1;
        end else if (r_cls_a == CLS_INF) begin
            w_res = POS_INF | {r_sign, 31'd0};
        end else if (r_cls_a == CLS_ZERO || r_cls_b == CLS_INF) begin
            w_res = {r_sign, 31'd0};
        end else if (w_exp_n >= 10'sd255) begin
            w_res = POS_INF | {r_sign, 31'd0};
            w_ovf = 1'b1;
        end else if (w_exp_n <= 10'sd0) begin
            w_res = {r_sign, 31'd0};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cls_a     <= CLS_ZERO;
            r_cls_b     <= CLS_ZERO;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cls_a <= fp_class_t'(w_cls_a);
                        r_cls_b <= fp_class_t'(w_cls_b);
                        r_sign  <= w_a.sign ^ w_b.sign;
                        r_exp   <= w_exp_in;
                        r_rem   <= {2'b01, w_a.mant};
                        r_div   <= {1'b1, w_b.mant};
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_ge) begin
                        r_q   <= {r_q[23:0], 1'b1};
                        r_rem <= {w_diff, 1'b0};
                    end else begin
                        r_q   <= {r_q[23:0], 1'b0};
                        r_rem <= {r_rem[23:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd24) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_result    <= w_res;
                    r_ovf       <= w_ovf;
                    r_unf       <= w_unf;
                    r_exc       <= w_exc;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign exception = r_exc;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for fp32_divider_seq: hand-computed quotients, flags, latency,
// back-pressure and mid-operation reset.
module tb_fp32_divider_seq;

    // Edges after the accepting edge until out_valid is seen (accept edge is #1 of 27).
    localparam int LAT = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        in_ready, out_valid, overflow, underflow, exception;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    fp32_divider_seq #(.XLEN(32), .BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .overflow(overflow), .underflow(underflow), .exception(exception)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] flg,
                         output int lat, output logic rdy_bad);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        rdy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
        end
        res = result;
        flg = {overflow, underflow, exception};
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, in_ready, overflow, underflow, exception} !== 5'b01000 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset: ov/ir/flags=%b result=%h expected 01000 / 00000000",
                     {out_valid, in_ready, overflow, underflow, exception}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res; logic [2:0] flg; int lat; logic rb;
        do_op(32'h40C00000, 32'h40000000, res, flg, lat, rb);
        tests++;
        if (res !== 32'h40400000) begin
            fails++; $display("FAIL 6/2 result: got %h expected 40400000", res);
        end
        tests++;
        if (flg !== 3'b000) begin
            fails++; $display("FAIL 6/2 flags: got %b expected 000", flg);
        end
        tests++;
        if (lat !== LAT) begin
            fails++; $display("FAIL 6/2 latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_one_third();
        logic [31:0] res; logic [2:0] flg; int lat; logic rb;
        do_op(32'h3F800000, 32'h40400000, res, flg, lat, rb);
        tests++;
        if (res !== 32'h3EAAAAAA || flg !== 3'b000) begin
            fails++; $display("FAIL 1/3: got %h/%b expected 3eaaaaaa/000", res, flg);
        end
        tests++;
        if (rb !== 1'b0) begin
            fails++; $display("FAIL 1/3 in_ready busy: got high expected low");
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [12] = '{32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7F000000,
                                 32'h00800000, 32'hC0C00000, 32'h7F800001, 32'h7F800000,
                                 32'h00000000, 32'hC0000000, 32'h00000000, 32'h00400000};
        logic [31:0] vb [12] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F000000,
                                 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000,
                                 32'h40000000, 32'h7F800000, 32'hC0000000, 32'h3F800000};
        logic [31:0] vr [12] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                                 32'h00000000, 32'hC0400000, 32'h7FC00000, 32'h7F800000,
                                 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000};
        logic [2:0]  vf [12] = '{3'b001, 3'b001, 3'b001, 3'b100,
                                 3'b010, 3'b000, 3'b001, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000};
        logic [31:0] res; logic [2:0] flg; int lat; logic rb;
        for (int i = 0; i < 12; i++) begin
            do_op(va[i], vb[i], res, flg, lat, rb);
            tests++;
            if (res !== vr[i] || flg !== vf[i] || lat !== LAT) begin
                fails++;
                $display("FAIL special %0d (%h/%h): got %h flags %b lat %0d expected %h flags %b lat %0d",
                         i, va[i], vb[i], res, flg, lat, vr[i], vf[i], LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; logic [2:0] flg; int lat; logic rb;
        out_ready = 1'b0;
        do_op(32'h40C00000, 32'h40000000, res, flg, lat, rb);
        tests++;
        if (res !== 32'h40400000 || flg !== 3'b000) begin
            fails++; $display("FAIL bp first result: got %h/%b expected 40400000/000", res, flg);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            A = 32'h3F800000 + 32'(i);
            B = 32'h40400000;
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 32'h40400000 ||
                {overflow, underflow, exception} !== 3'b000) begin
                fails++;
                $display("FAIL bp hold %0d: ov/ir=%b result=%h flags=%b expected 10/40400000/000",
                         i, {out_valid, in_ready}, result, {overflow, underflow, exception});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++; $display("FAIL bp release: ov/ir=%b expected 01", {out_valid, in_ready});
        end
        do_op(32'h3F800000, 32'h40400000, res, flg, lat, rb);
        tests++;
        if (res !== 32'h3EAAAAAA || lat !== LAT) begin
            fails++; $display("FAIL bp next op: got %h lat %0d expected 3eaaaaaa lat %0d", res, lat, LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [2:0] flg; int lat; logic rb;
        int seen;
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b01 || result !== 32'h0) begin
            fails++;
            $display("FAIL mid reset: ov/ir=%b result=%h expected 01/00000000", {out_valid, in_ready}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL mid reset silent: out_valid high %0d cycles expected 0", seen);
        end
        do_op(32'h40C00000, 32'h40000000, res, flg, lat, rb);
        tests++;
        if (res !== 32'h40400000 || flg !== 3'b000 || lat !== LAT) begin
            fails++; $display("FAIL post-reset 6/2: got %h/%b lat %0d expected 40400000/000 lat %0d",
                              res, flg, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_one_third();
        test_specials();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
